// File: rtl/updown_counter_param_if.sv
// rtl/updown_counter_param_if.sv - control/status bundle for updown_counter_param (UDC_STICKY_FLAG_EN adds flag_clr/flag_sticky)
interface updown_counter_param_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             ld;
    logic             up_dn;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             evt;
`ifdef UDC_STICKY_FLAG_EN
    logic             flag_clr;
    logic             flag_sticky;

    modport master (
        output en, ld, up_dn, data_in, flag_clr,
        input  count, tc, evt, flag_sticky
    );
    modport slave (
        input  en, ld, up_dn, data_in, flag_clr,
        output count, tc, evt, flag_sticky
    );
`else
    modport master (
        output en, ld, up_dn, data_in,
        input  count, tc, evt
    );
    modport slave (
        input  en, ld, up_dn, data_in,
        output count, tc, evt
    );
`endif
endinterface

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - up/down counter with load, modulus, wrap/saturate, tc and evt (UDC_STICKY_FLAG_EN adds sticky boundary flag)
module updown_counter_param #(
    parameter int          WIDTH       = 3,
    parameter int unsigned MAX_COUNT   = (2**WIDTH) - 1,
    parameter bit          SATURATE    = 1'b0,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_counter_param_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             evt_q;
    logic             evt_nxt;
    logic             at_top;
    logic             at_bot;

    assign at_top = (count_q == MAX_C);
    assign at_bot = (count_q == '0);

    // Boundary detection compares against MAX_C so non-power-of-2 moduli wrap cleanly.
    always_comb begin
        count_nxt = count_q;
        evt_nxt   = 1'b0;
        if (bus.ld) begin
            count_nxt = (bus.data_in > MAX_C) ? MAX_C : bus.data_in;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (at_top) begin
                    evt_nxt   = 1'b1;
                    count_nxt = SATURATE ? count_q : '0;
                end else begin
                    count_nxt = count_q + ONE;
                end
            end else begin
                if (at_bot) begin
                    evt_nxt   = 1'b1;
                    count_nxt = SATURATE ? count_q : MAX_C;
                end else begin
                    count_nxt = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_C;
            evt_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            evt_q   <= evt_nxt;
        end
    end

    assign bus.count = count_q;
    assign bus.evt   = evt_q;
    // tc ignores en so that a chain can be built as en_next = en & tc.
    assign bus.tc    = (bus.up_dn & at_top) | (~bus.up_dn & at_bot);

`ifdef UDC_STICKY_FLAG_EN
    logic flag_q;

    // A new boundary event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
        end else if (evt_nxt) begin
            flag_q <= 1'b1;
        end else if (bus.flag_clr) begin
            flag_q <= 1'b0;
        end
    end

    assign bus.flag_sticky = flag_q;
`endif
endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - directed bench for wrap and saturate instances of updown_counter_param
module tb_updown_counter_param;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       ld;
    logic       up_dn;
    logic [2:0] data_in;
`ifdef UDC_STICKY_FLAG_EN
    logic       flag_clr;
`endif
    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    updown_counter_param_if #(.WIDTH(3)) bus_w ();
    updown_counter_param_if #(.WIDTH(3)) bus_s ();

    assign bus_w.en = en;      assign bus_s.en = en;
    assign bus_w.ld = ld;      assign bus_s.ld = ld;
    assign bus_w.up_dn = up_dn;   assign bus_s.up_dn = up_dn;
    assign bus_w.data_in = data_in; assign bus_s.data_in = data_in;
`ifdef UDC_STICKY_FLAG_EN
    assign bus_w.flag_clr = flag_clr; assign bus_s.flag_clr = flag_clr;
`endif

    updown_counter_param #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1'b0), .RESET_VALUE(0)) dut_w (
        .clk(clk), .reset(reset), .bus(bus_w)
    );
    updown_counter_param #(.WIDTH(3), .MAX_COUNT(5), .SATURATE(1'b1), .RESET_VALUE(3)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected count/evt for the wrap instance (w) and the saturate instance (s).
    task automatic chk_both(input string tag, input int wc, input int we, input int sc, input int se);
        chk({tag, "/w_count"}, bus_w.count, wc);
        chk({tag, "/w_evt"},   bus_w.evt,   we);
        chk({tag, "/s_count"}, bus_s.count, sc);
        chk({tag, "/s_evt"},   bus_s.evt,   se);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; ld = 1'b0; up_dn = 1'b1; data_in = 3'd0;
`ifdef UDC_STICKY_FLAG_EN
        flag_clr = 1'b0;
`endif
        step();
        chk_both("reset", 0, 0, 3, 0);

        reset = 1'b0; ld = 1'b1; data_in = 3'd3;
        step();
        chk_both("load3", 3, 0, 3, 0);
        data_in = 3'd7;
        step();
        chk_both("load7_clamp", 5, 0, 5, 0);

        data_in = 3'd4;
        step();
        chk_both("load4", 4, 0, 4, 0);
        ld = 1'b0; en = 1'b1; up_dn = 1'b1;
        step();
        chk_both("up1", 5, 0, 5, 0);
        chk("up1/w_tc", bus_w.tc, 1);
        step();
        chk_both("up2_wrap", 0, 1, 5, 1);
        chk("up2/w_tc", bus_w.tc, 0);
        chk("up2/s_tc", bus_s.tc, 1);
        step();
        chk_both("up3", 1, 0, 5, 1);

        ld = 1'b1; data_in = 3'd1;
        step();
        chk_both("prio_load1", 1, 0, 1, 0);
        ld = 1'b0; up_dn = 1'b0;
        step();
        chk_both("dn1", 0, 0, 0, 0);
        chk("dn1/w_tc", bus_w.tc, 1);
        step();
        chk_both("dn2_wrap", 5, 1, 0, 1);
        chk("dn2/w_tc", bus_w.tc, 0);
        step();
        chk_both("dn3", 4, 0, 0, 1);

        ld = 1'b1; data_in = 3'd5;
        step();
        chk_both("load5", 5, 0, 5, 0);
        ld = 1'b0; up_dn = 1'b1;
        step();
        chk_both("sat1", 0, 1, 5, 1);
        step();
        chk_both("sat2", 1, 0, 5, 1);
        step();
        chk_both("sat3", 2, 0, 5, 1);
        up_dn = 1'b0;
        step();
        chk_both("sat_dn", 1, 0, 4, 0);

        ld = 1'b1; en = 1'b1; up_dn = 1'b1; data_in = 3'd2;
        step();
        chk_both("prio_ld_en", 2, 0, 2, 0);
        data_in = 3'd5;
        step();
        ld = 1'b0;
        step();
        chk_both("pre_reset_evt", 0, 1, 5, 1);
`ifdef UDC_STICKY_FLAG_EN
        chk("pre_reset/w_flag", bus_w.flag_sticky, 1);
`endif
        reset = 1'b1; ld = 1'b1; en = 1'b1; data_in = 3'd4;
        step();
        chk_both("reset_mid", 0, 0, 3, 0);
`ifdef UDC_STICKY_FLAG_EN
        chk("reset_mid/w_flag", bus_w.flag_sticky, 0);
        chk("reset_mid/s_flag", bus_s.flag_sticky, 0);
`endif
        reset = 1'b0; ld = 1'b0; en = 1'b0; up_dn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_both($sformatf("hold%0d", i), 0, 0, 3, 0);
        end
        chk("hold/w_tc_no_en", bus_w.tc, 1);
        chk("hold/s_tc", bus_s.tc, 0);

`ifdef UDC_STICKY_FLAG_EN
        ld = 1'b1; data_in = 3'd5;
        step();
        ld = 1'b0; en = 1'b1; up_dn = 1'b1;
        step();
        chk_both("stk_wrap", 0, 1, 5, 1);
        chk("stk_wrap/w_flag", bus_w.flag_sticky, 1);
        en = 1'b0;
        step();
        chk("stk_hold/w_evt", bus_w.evt, 0);
        chk("stk_hold/w_flag", bus_w.flag_sticky, 1);
        ld = 1'b1; data_in = 3'd5;
        step();
        ld = 1'b0; en = 1'b1; flag_clr = 1'b1;
        step();
        chk("stk_setclr/w_flag", bus_w.flag_sticky, 1);
        chk("stk_setclr/s_flag", bus_s.flag_sticky, 1);
        en = 1'b0;
        step();
        chk("stk_clr/w_flag", bus_w.flag_sticky, 0);
        chk("stk_clr/s_flag", bus_s.flag_sticky, 0);
        flag_clr = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
